irq_pending_arbiter: RTL and testbench

Sequential front end that drives the 32-input priority encoder stage. It captures request events on 32 lines into a sticky pending register and applies a mask. It then presents the highest-priority pending, unmasked line as a 5-bit index under a valid/ack handshake, and clears that line's pending bit on acknowledge. It sits between raw interrupt/request sources and any consumer of an encoded line number.

---
 rtl/irq_pending_arbiter.sv | 59 +++++
 tb/tb_irq_pending_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: sticky pending capture with fixed-priority valid/ack grant of the highest unmasked line
module irq_pending_arbiter #(
  parameter int N = 32,
  parameter int IW = 5,
  parameter bit EDGE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic          ack,
  output logic [N-1:0]  pend,
  output logic          valid,
  output logic [IW-1:0] id,
  output logic          any,
  output logic          lost
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [N-1:0] evt, clr, cand;
  logic [IW-1:0] win;
  logic load;
  assign cand = pend & ~mask;
  assign any  = |cand;
  assign clr  = (valid && ack) ? ({{(N-1){1'b0}}, 1'b1} << id) : '0;
  assign load = (state == IDLE) && en && any;
  generate
    if (EDGE) begin : g_edge
      logic [N-1:0] req_q;
      always_ff @(posedge clk) req_q <= req;
      assign evt = req & ~req_q;
    end else begin : g_level
      assign evt = req;
    end
  endgenerate
  // ascending scan so the highest set bit is the last one written
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++)
      if (cand[i]) win = IW'(i);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (load ? GRANT : IDLE) : (ack ? IDLE : GRANT);
  always_comb valid = (state == GRANT);
  always_ff @(posedge clk)
    if (rst) begin
      pend <= '0;
      id   <= '0;
      lost <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | evt;
      lost <= |(evt & pend & ~clr);
      if (load) id <= win;
    end
endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb_irq_pending_arbiter: directed scenarios plus randomized run against a behavioural model
module tb_irq_pending_arbiter;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, ack = 1'b0, ack2 = 1'b0;
  logic [31:0] req = '0, mask = '0, req2 = '0;
  logic [31:0] pend, pend2;
  logic valid, valid2, any, any2, lost, lost2;
  logic [4:0] id, id2;
  int checks = 0, errors = 0;
  logic [31:0] m_pend, m_prev, evt, clr;
  logic m_valid, m_lost;
  logic [4:0] m_id;

  always #5 clk = ~clk;

  irq_pending_arbiter #(.N(32), .IW(5), .EDGE(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .mask(mask), .ack(ack),
    .pend(pend), .valid(valid), .id(id), .any(any), .lost(lost));

  irq_pending_arbiter #(.N(32), .IW(5), .EDGE(1'b0)) dut_lvl (
    .clk(clk), .rst(rst), .en(en), .req(req2), .mask(mask), .ack(ack2),
    .pend(pend2), .valid(valid2), .id(id2), .any(any2), .lost(lost2));

  function automatic logic [4:0] top_bit(input logic [31:0] v);
    for (int i = 31; i >= 0; i--)
      if (v[i]) return 5'(i);
    return 5'd0;
  endfunction

  // reference model for the edge-mode instance
  always @(posedge clk) begin
    if (rst) begin
      m_pend = '0; m_valid = 1'b0; m_id = '0; m_lost = 1'b0; m_prev = req;
    end else begin
      evt = req & ~m_prev;
      m_prev = req;
      clr = '0;
      if (m_valid && ack) clr[m_id] = 1'b1;
      m_lost = (evt & m_pend & ~clr) != 0;
      if (m_valid) begin
        if (ack) m_valid = 1'b0;
      end else if (en && (m_pend & ~mask) != 0) begin
        m_valid = 1'b1;
        m_id = top_bit(m_pend & ~mask);
      end
      m_pend = (m_pend & ~clr) | evt;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; step(2); rst = 1'b0;
    checks++; if (pend !== 32'h0) begin errors++; $display("FAIL reset_pend got=%h exp=0", pend); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (id !== 5'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", id); end
    checks++; if (lost !== 1'b0 || any !== 1'b0) begin errors++; $display("FAIL reset_lost_any got=%b%b exp=00", lost, any); end
  endtask

  task automatic test_single;
    en = 1'b1; req = 32'h1; step;
    req = '0;
    checks++; if (pend !== 32'h1 || valid !== 1'b0 || any !== 1'b1) begin errors++; $display("FAIL single_capture pend=%h valid=%b any=%b exp 1/0/1", pend, valid, any); end
    step;
    checks++; if (valid !== 1'b1 || id !== 5'd0) begin errors++; $display("FAIL single_grant valid=%b id=%0d exp 1/0", valid, id); end
    ack = 1'b1; step; ack = 1'b0;
    checks++; if (valid !== 1'b0 || pend !== 32'h0) begin errors++; $display("FAIL single_ack valid=%b pend=%h exp 0/0", valid, pend); end
  endtask

  task automatic test_priority;
    logic [4:0] exp_ids [3] = '{5'd31, 5'd2, 5'd0};
    req = 32'h8000_0005; step; req = '0;
    checks++; if (pend !== 32'h8000_0005) begin errors++; $display("FAIL prio_pend got=%h exp=80000005", pend); end
    for (int k = 0; k < 3; k++) begin
      step;
      checks++; if (valid !== 1'b1 || id !== exp_ids[k]) begin errors++; $display("FAIL prio_grant%0d valid=%b id=%0d exp id=%0d", k, valid, id, exp_ids[k]); end
      ack = 1'b1; step; ack = 1'b0;
    end
    checks++; if (pend !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL prio_drain pend=%h valid=%b exp 0/0", pend, valid); end
  endtask

  task automatic test_mask_en;
    en = 1'b0; mask = 32'h20; req = 32'h30; step; req = '0; step(2);
    checks++; if (valid !== 1'b0 || any !== 1'b1 || pend !== 32'h30) begin errors++; $display("FAIL en_off valid=%b any=%b pend=%h exp 0/1/30", valid, any, pend); end
    en = 1'b1; step;
    checks++; if (valid !== 1'b1 || id !== 5'd4) begin errors++; $display("FAIL mask_grant valid=%b id=%0d exp 1/4", valid, id); end
    mask = 32'hFFFF_FFFF; en = 1'b0; step(2);
    checks++; if (valid !== 1'b1 || id !== 5'd4 || any !== 1'b0) begin errors++; $display("FAIL mask_hold valid=%b id=%0d any=%b exp 1/4/0", valid, id, any); end
    mask = '0; en = 1'b1; ack = 1'b1; step; ack = 1'b0;
    checks++; if (valid !== 1'b0 || pend !== 32'h20) begin errors++; $display("FAIL mask_ack valid=%b pend=%h exp 0/20", valid, pend); end
    step;
    checks++; if (valid !== 1'b1 || id !== 5'd5) begin errors++; $display("FAIL mask_next valid=%b id=%0d exp 1/5", valid, id); end
    ack = 1'b1; step; ack = 1'b0;
  endtask

  task automatic test_set_wins_lost;
    req = 32'h10; step; req = '0; step;
    checks++; if (valid !== 1'b1 || id !== 5'd4) begin errors++; $display("FAIL sw_grant valid=%b id=%0d exp 1/4", valid, id); end
    req = 32'h10; ack = 1'b1; step; req = '0; ack = 1'b0;
    checks++; if (pend !== 32'h10 || lost !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL set_wins pend=%h lost=%b valid=%b exp 10/0/0", pend, lost, valid); end
    step;
    checks++; if (valid !== 1'b1 || id !== 5'd4) begin errors++; $display("FAIL sw_regrant valid=%b id=%0d exp 1/4", valid, id); end
    ack = 1'b1; step; ack = 1'b0;
    en = 1'b0; req = 32'h80; step; req = '0; step; req = 32'h80; step; req = '0;
    checks++; if (lost !== 1'b1) begin errors++; $display("FAIL lost_pulse got=%b exp=1", lost); end
    step;
    checks++; if (lost !== 1'b0 || pend !== 32'h80) begin errors++; $display("FAIL lost_clear lost=%b pend=%h exp 0/80", lost, pend); end
    en = 1'b1; step; ack = 1'b1; step; ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    req = 32'hFFFF_FFFF; step(2);
    checks++; if (valid !== 1'b1 || id !== 5'd31) begin errors++; $display("FAIL rm_grant valid=%b id=%0d exp 1/31", valid, id); end
    rst = 1'b1; ack = 1'b1; step; rst = 1'b0; ack = 1'b0;
    checks++; if (valid !== 1'b0 || pend !== 32'h0) begin errors++; $display("FAIL rm_reset valid=%b pend=%h exp 0/0", valid, pend); end
    step(3);
    checks++; if (valid !== 1'b0 || pend !== 32'h0) begin errors++; $display("FAIL rm_no_recapture valid=%b pend=%h exp 0/0", valid, pend); end
    req = '0; step;
  endtask

  task automatic test_level;
    req2 = 32'h8; step;
    checks++; if (pend2 !== 32'h8) begin errors++; $display("FAIL lvl_pend got=%h exp=8", pend2); end
    step;
    checks++; if (valid2 !== 1'b1 || id2 !== 5'd3) begin errors++; $display("FAIL lvl_grant valid=%b id=%0d exp 1/3", valid2, id2); end
    ack2 = 1'b1; step; ack2 = 1'b0;
    checks++; if (valid2 !== 1'b0 || pend2 !== 32'h8 || lost2 !== 1'b0) begin errors++; $display("FAIL lvl_repend valid=%b pend=%h lost=%b exp 0/8/0", valid2, pend2, lost2); end
    step;
    checks++; if (valid2 !== 1'b1 || id2 !== 5'd3) begin errors++; $display("FAIL lvl_regrant valid=%b id=%0d exp 1/3", valid2, id2); end
    req2 = '0; ack2 = 1'b1; step; ack2 = 1'b0;
  endtask

  task automatic test_random;
    for (int c = 0; c < 3000; c++) begin
      checks++; if (pend !== m_pend) begin errors++; $display("FAIL rnd_pend cyc=%0d got=%h exp=%h", c, pend, m_pend); end
      checks++; if (valid !== m_valid || (m_valid && id !== m_id)) begin errors++; $display("FAIL rnd_grant cyc=%0d valid=%b id=%0d exp %b/%0d", c, valid, id, m_valid, m_id); end
      checks++; if (lost !== m_lost) begin errors++; $display("FAIL rnd_lost cyc=%0d got=%b exp=%b", c, lost, m_lost); end
      checks++; if (any !== ((m_pend & ~mask) != 0)) begin errors++; $display("FAIL rnd_any cyc=%0d got=%b", c, any); end
      req  = $urandom & $urandom & $urandom;
      mask = $urandom & $urandom;
      en   = ($urandom_range(3) != 0);
      ack  = $urandom_range(1);
      rst  = ($urandom_range(199) == 0);
      step;
    end
    rst = 1'b0; ack = 1'b0; req = '0; mask = '0;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_priority;
    test_mask_en;
    test_set_wins_lost;
    test_reset_mid;
    test_level;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
